prog_feeder: RTL and testbench
==============================

// Module: prog_feeder
// PURPOSE
//  Program sequencer for the 9-bit processor datapath; drives its DIN/run inputs and consumes its Done.
//  Reads instruction words (format III_XXX_YYY) from an external synchronous program ROM (1-cycle read latency).
//  Issues each instruction with a one-cycle run pulse and holds DIN until Done.
//  For mvi, prefetches the immediate word and presents it on DIN after the run pulse.
// PARAMETERS
//  ADDR_W      5        ROM address width
//  PROG_LEN    32       words in program; fetch at pc==PROG_LEN halts (PROG_LEN <= 2**ADDR_W)
//  MVI_OP      3'b001   opcode whose instruction is followed by an immediate word
//  HALT_WORD   9'h1FF   word that ends the program when fetched as an instruction
//  TIMEOUT_CYC 15       EXEC cycles allowed before Done (FEEDER_TIMEOUT_EN only)
// PORTS
//  clk          in   1       clock, rising edge
//  rst          in   1       reset; asynchronous, active-high
//  start        in   1       level; sampled in IDLE/HALT to begin at pc=0
//  done         in   1       processor Done
//  rom_data     in   9       ROM read data, valid 1 cycle after rom_addr
//  rom_addr     out  ADDR_W  ROM address (the pc)
//  din          out  9       to processor DIN
//  run          out  1       to processor run; 1-cycle pulse per instruction
//  busy         out  1       high in every state except IDLE/HALT
//  halted       out  1       high in HALT
//  err          out  1       sticky until next start/reset; program fault
//  instr_count  out  8       completed instructions, saturates at 255
//  state        out  3       current FSM state encoding (debug)
// BEHAVIOUR
//  Reset: state=IDLE(0), rom_addr=0, din=0, run=0, busy=0, halted=0, err=0, instr_count=0. Async; mid-op abort.
//  States: IDLE=0 FETCH_I=1 CAP_I=2 CAP_D=3 ISSUE=4 EXEC=5 HALT=6.
//  IDLE/HALT: start=1 -> pc=0, err=0, instr_count=0, FETCH_I. Else stay.
//  FETCH_I: rom_addr=pc; -> CAP_I. (pc>=PROG_LEN -> HALT instead.)
//  CAP_I: ir<=rom_data. rom_data==HALT_WORD -> HALT. opcode==MVI_OP: if pc==PROG_LEN-1 -> err=1, HALT;
//    else rom_addr=pc+1 -> CAP_D. Otherwise -> ISSUE.
//  CAP_D: imm<=rom_data; -> ISSUE.
//  ISSUE: din=ir, run=1 for exactly this cycle; -> EXEC.
//  EXEC: din=imm if mvi else ir; run=0; done sampled only here. done=1 -> pc+=2 (mvi) or 1,
//    instr_count+=1 (sat), -> FETCH_I. done in any other state ignored.
//  Latency: non-mvi run pulse 3 cycles after FETCH_I entry; mvi 4. Next fetch cycle after Done.
//  din holds last value in FETCH_I/CAP_*/HALT; changes only on ISSUE/EXEC entry.
//  start while busy ignored. pc computed at ADDR_W+1 bits; no wrap, end-of-program halts.
//  halted=1 exactly when state==HALT; busy=!(IDLE||HALT).
// CONFIGURATION
//  FEEDER_TIMEOUT_EN defined: counter cleared on EXEC entry, +1 per EXEC cycle without done;
//    reaching TIMEOUT_CYC -> err=1, HALT, instruction not counted. done on the cycle the count
//    reaches TIMEOUT_CYC wins (normal completion).
//  Not defined: EXEC waits for done indefinitely; no counter logic; err set only by mvi-at-end fault.
// TESTING
//  ROM={9'h040(mvi R0),9'h005,HALT_WORD}, done 3 cyc after run -> din 9'h040 at run, then 9'h005; halt, instr_count=1.
//  ROM={mv R1,R0 (9'h008), add R0,R1 (9'h081), HALT_WORD} -> two run pulses, rom_addr 0,1,2; halted=1, err=0.
//  PROG_LEN=2, ROM[1]=mvi -> no second run pulse, err=1, halted=1, instr_count=1.
//  rst asserted during EXEC -> same cycle: run=0, din=0, state=0, busy=0; next start restarts at rom_addr=0.
//  done pulsed in IDLE/CAP_I and start pulsed in EXEC -> no effect on pc/state.
//  FEEDER_TIMEOUT_EN, done never asserted -> HALT after 15 EXEC cycles, err=1, instr_count unchanged.

Source files
------------

// File: rtl/prog_feeder.sv
// rtl/prog_feeder.sv - program sequencer: fetches 9-bit instructions from a synchronous ROM and drives a processor's din/run
// Optional EXEC watchdog enabled by defining FEEDER_TIMEOUT_EN.
module prog_feeder #(
    parameter int         ADDR_W      = 5,
    parameter int         PROG_LEN    = 32,
    parameter logic [2:0] MVI_OP      = 3'b001,
    parameter logic [8:0] HALT_WORD   = 9'h1FF,
    parameter int         TIMEOUT_CYC = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              done,
    input  logic [8:0]        rom_data,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [8:0]        din,
    output logic              run,
    output logic              busy,
    output logic              halted,
    output logic              err,
    output logic [7:0]        instr_count,
    output logic [2:0]        state
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH_I = 3'd1,
        CAP_I   = 3'd2,
        CAP_D   = 3'd3,
        ISSUE   = 3'd4,
        EXEC    = 3'd5,
        HALT    = 3'd6
    } state_t;

    localparam logic [ADDR_W:0] LEN  = (ADDR_W+1)'(PROG_LEN);
    localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(PROG_LEN - 1);

    state_t          st;
    logic [ADDR_W:0] pc;
    logic [ADDR_W:0] npc;
    logic [8:0]      ir;
    logic [8:0]      imm;
    logic            ir_mvi;

`ifdef FEEDER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tcount;
`endif

    assign state  = st;
    assign ir_mvi = (ir[8:6] == MVI_OP);
    assign npc    = pc + (ir_mvi ? (ADDR_W+1)'(2) : (ADDR_W+1)'(1));

    // rom_addr advances to pc+1 on CAP_I entry so an mvi immediate is already
    // on rom_data in CAP_D; for other instructions that read is simply unused.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st          <= IDLE;
            pc          <= '0;
            ir          <= '0;
            imm         <= '0;
            rom_addr    <= '0;
            din         <= '0;
            run         <= 1'b0;
            busy        <= 1'b0;
            halted      <= 1'b0;
            err         <= 1'b0;
            instr_count <= '0;
`ifdef FEEDER_TIMEOUT_EN
            tcount      <= '0;
`endif
        end else begin
            run <= 1'b0;
            case (st)
                IDLE, HALT: begin
                    if (start) begin
                        pc          <= '0;
                        rom_addr    <= '0;
                        err         <= 1'b0;
                        instr_count <= '0;
                        busy        <= 1'b1;
                        halted      <= 1'b0;
                        st          <= FETCH_I;
                    end
                end
                FETCH_I: begin
                    if (pc >= LEN) begin
                        busy   <= 1'b0;
                        halted <= 1'b1;
                        st     <= HALT;
                    end else begin
                        rom_addr <= pc[ADDR_W-1:0] + ADDR_W'(1);
                        st       <= CAP_I;
                    end
                end
                CAP_I: begin
                    ir <= rom_data;
                    if (rom_data == HALT_WORD) begin
                        busy   <= 1'b0;
                        halted <= 1'b1;
                        st     <= HALT;
                    end else if (rom_data[8:6] == MVI_OP) begin
                        // An mvi in the last word has no immediate to read.
                        if (pc == LAST) begin
                            err    <= 1'b1;
                            busy   <= 1'b0;
                            halted <= 1'b1;
                            st     <= HALT;
                        end else begin
                            st <= CAP_D;
                        end
                    end else begin
                        din <= rom_data;
                        run <= 1'b1;
                        st  <= ISSUE;
                    end
                end
                CAP_D: begin
                    imm <= rom_data;
                    din <= ir;
                    run <= 1'b1;
                    st  <= ISSUE;
                end
                ISSUE: begin
                    din <= ir_mvi ? imm : ir;
`ifdef FEEDER_TIMEOUT_EN
                    tcount <= '0;
`endif
                    st  <= EXEC;
                end
                EXEC: begin
                    if (done) begin
                        pc       <= npc;
                        rom_addr <= npc[ADDR_W-1:0];
                        if (instr_count != 8'hFF) begin
                            instr_count <= instr_count + 8'd1;
                        end
                        st <= FETCH_I;
                    end
`ifdef FEEDER_TIMEOUT_EN
                    else if (tcount == TW'(TIMEOUT_CYC - 1)) begin
                        err    <= 1'b1;
                        busy   <= 1'b0;
                        halted <= 1'b1;
                        st     <= HALT;
                    end else begin
                        tcount <= tcount + TW'(1);
                    end
`endif
                end
                default: begin
                    busy   <= 1'b0;
                    halted <= 1'b0;
                    st     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_prog_feeder.sv
// tb/tb_prog_feeder.sv - directed self-checking bench for prog_feeder (PROG_LEN=3, ROM and processor modelled here)
// Optional: define FEEDER_TIMEOUT_EN to check the EXEC watchdog.
module tb_prog_feeder;
    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       force_done;
    logic       resp_done = 1'b0;
    logic       done;
    logic [8:0] rom_data = '0;
    logic [4:0] rom_addr;
    logic [8:0] din;
    logic       run;
    logic       busy;
    logic       halted;
    logic       err;
    logic [7:0] instr_count;
    logic [2:0] state;

    logic [8:0] rom [0:31];
    int         n_checks = 0;
    int         n_errors = 0;

    // processor model: answers each run pulse with a one-cycle done after auto_dly cycles
    logic       auto_en;
    int         auto_dly;
    int         cnt = 0;
    int         cyc = 0;
    int         fetch_cyc = 0;
    int         run_cnt = 0;
    int         fetch_cnt = 0;
    int         exec_cycles = 0;
    logic       exec_pend = 1'b0;
    logic [8:0] run_din   [0:255];
    logic [8:0] exec_din  [0:255];
    int         run_lat   [0:255];
    logic [4:0] fetch_addr[0:255];

    assign done = resp_done | force_done;

    prog_feeder #(.PROG_LEN(3)) u_dut (
        .clk(clk), .rst(rst), .start(start), .done(done), .rom_data(rom_data),
        .rom_addr(rom_addr), .din(din), .run(run), .busy(busy), .halted(halted),
        .err(err), .instr_count(instr_count), .state(state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom[rom_addr];

    always @(negedge clk) begin
        cyc = cyc + 1;
        resp_done = 1'b0;
        if (auto_en && cnt > 0) begin
            cnt = cnt - 1;
            if (cnt == 0) resp_done = 1'b1;
        end
        if (state == 3'd1) begin
            fetch_addr[fetch_cnt] = rom_addr;
            fetch_cnt = fetch_cnt + 1;
            fetch_cyc = cyc;
        end
        if (state == 3'd5) exec_cycles = exec_cycles + 1;
        if (exec_pend) begin
            exec_din[run_cnt-1] = din;
            exec_pend = 1'b0;
        end
        if (run) begin
            run_din[run_cnt] = din;
            run_lat[run_cnt] = cyc - fetch_cyc + 1;
            run_cnt = run_cnt + 1;
            exec_pend = 1'b1;
            if (auto_en) cnt = auto_dly;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_state(input logic [2:0] s, input int max, input string tag);
        int n = 0;
        while (state != s && n < max) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(state), 32'(s));
    endtask

    task automatic kick();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic load(input logic [8:0] w0, input logic [8:0] w1, input logic [8:0] w2);
        rom[0] = w0;
        rom[1] = w1;
        rom[2] = w2;
    endtask

    initial begin
        int rb, fb, eb;
        for (int i = 0; i < 32; i++) rom[i] = 9'h000;
        rst = 1'b1; start = 1'b0; force_done = 1'b0; auto_en = 1'b1; auto_dly = 3;
        repeat (2) @(negedge clk);
        check("rst_state", 32'(state), 0);
        check("rst_rom_addr", 32'(rom_addr), 0);
        check("rst_din", 32'(din), 0);
        check("rst_run", 32'(run), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_halted", 32'(halted), 0);
        check("rst_err", 32'(err), 0);
        check("rst_count", 32'(instr_count), 0);
        rst = 1'b0;

        // done in IDLE ignored
        force_done = 1'b1;
        @(negedge clk);
        force_done = 1'b0;
        @(negedge clk);
        check("idle_done_state", 32'(state), 0);

        // mvi R0 then HALT_WORD
        load(9'h040, 9'h005, 9'h1FF);
        rb = run_cnt;
        kick();
        check("start_busy", 32'(busy), 1);
        wait_state(3'd6, 100, "A_halt");
        check("A_runs", 32'(run_cnt - rb), 1);
        check("A_din_run", 32'(run_din[rb]), 32'h040);
        check("A_din_exec", 32'(exec_din[rb]), 32'h005);
        check("A_lat", 32'(run_lat[rb]), 4);
        check("A_count", 32'(instr_count), 1);
        check("A_halted", 32'(halted), 1);
        check("A_busy", 32'(busy), 0);
        check("A_err", 32'(err), 0);

        // mv R1,R0 ; add R0,R1 ; HALT_WORD
        load(9'h008, 9'h081, 9'h1FF);
        rb = run_cnt; fb = fetch_cnt;
        kick();
        wait_state(3'd6, 100, "B_halt");
        check("B_runs", 32'(run_cnt - rb), 2);
        check("B_din0", 32'(run_din[rb]), 32'h008);
        check("B_din1", 32'(run_din[rb+1]), 32'h081);
        check("B_din1_exec", 32'(exec_din[rb+1]), 32'h081);
        check("B_lat", 32'(run_lat[rb]), 3);
        check("B_fetches", 32'(fetch_cnt - fb), 3);
        check("B_addr0", 32'(fetch_addr[fb]), 0);
        check("B_addr1", 32'(fetch_addr[fb+1]), 1);
        check("B_addr2", 32'(fetch_addr[fb+2]), 2);
        check("B_count", 32'(instr_count), 2);
        check("B_err", 32'(err), 0);

        // mvi in the last program word
        load(9'h008, 9'h081, 9'h040);
        rb = run_cnt;
        kick();
        wait_state(3'd6, 100, "C_halt");
        check("C_runs", 32'(run_cnt - rb), 2);
        check("C_err", 32'(err), 1);
        check("C_halted", 32'(halted), 1);
        check("C_count", 32'(instr_count), 2);
        check("C_din_hold", 32'(din), 32'h081);

        // end of program without HALT_WORD; start clears err
        load(9'h008, 9'h010, 9'h018);
        fb = fetch_cnt;
        kick();
        check("D_err_clr", 32'(err), 0);
        wait_state(3'd6, 100, "D_halt");
        check("D_count", 32'(instr_count), 3);
        check("D_fetches", 32'(fetch_cnt - fb), 4);
        check("D_addr_end", 32'(fetch_addr[fb+3]), 3);
        check("D_err", 32'(err), 0);

        // done in CAP_I ignored, start in EXEC ignored, then reset mid-EXEC
        load(9'h008, 9'h1FF, 9'h000);
        auto_en = 1'b0;
        kick();
        wait_state(3'd2, 20, "E_capi");
        force_done = 1'b1;
        @(negedge clk);
        force_done = 1'b0;
        check("E_issue", 32'(state), 4);
        check("E_run", 32'(run), 1);
        @(negedge clk);
        kick();
        check("E_start_exec", 32'(state), 5);
        check("E_count0", 32'(instr_count), 0);
        rst = 1'b1;
        #1;
        check("E_rst_run", 32'(run), 0);
        check("E_rst_din", 32'(din), 0);
        check("E_rst_state", 32'(state), 0);
        check("E_rst_busy", 32'(busy), 0);
        @(negedge clk);
        rst = 1'b0;
        auto_en = 1'b1;
        fb = fetch_cnt;
        kick();
        wait_state(3'd6, 100, "E_halt");
        check("E_refetch", 32'(fetch_addr[fb]), 0);
        check("E_count", 32'(instr_count), 1);

        // processor never answers
        auto_en = 1'b0;
        kick();
        wait_state(3'd5, 20, "F_exec");
        eb = exec_cycles;
`ifdef FEEDER_TIMEOUT_EN
        wait_state(3'd6, 40, "F_timeout_halt");
        check("F_exec_cycles", 32'(exec_cycles - eb), 15);
        check("F_err", 32'(err), 1);
        check("F_count", 32'(instr_count), 0);
`else
        repeat (40) @(negedge clk);
        check("F_still_exec", 32'(state), 5);
        check("F_err", 32'(err), 0);
        force_done = 1'b1;
        @(negedge clk);
        force_done = 1'b0;
        wait_state(3'd6, 20, "F_halt");
        check("F_count", 32'(instr_count), 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
